// File: rtl/msrh_l2_if.sv
// L2 request/response bundle between the tile (master) and an L2 responder (slave).
interface msrh_l2_if #(
  parameter int PADDR_W = 32,
  parameter int LINE_W  = 256,
  parameter int TAG_W   = 4
);
  localparam int LINE_BYTES = LINE_W / 8;

  logic                  i_req_valid;
  logic                  o_req_ready;
  logic                  i_req_cmd;
  logic [PADDR_W-1:0]    i_req_addr;
  logic [TAG_W-1:0]      i_req_tag;
  logic [LINE_W-1:0]     i_req_data;
  logic [LINE_BYTES-1:0] i_req_byte_en;
  logic                  o_resp_valid;
  logic                  i_resp_ready;
  logic [TAG_W-1:0]      o_resp_tag;
  logic [LINE_W-1:0]     o_resp_data;

  modport master (
    output i_req_valid, i_req_cmd, i_req_addr, i_req_tag, i_req_data, i_req_byte_en, i_resp_ready,
    input  o_req_ready, o_resp_valid, o_resp_tag, o_resp_data
  );

  modport slave (
    input  i_req_valid, i_req_cmd, i_req_addr, i_req_tag, i_req_data, i_req_byte_en, i_resp_ready,
    output o_req_ready, o_resp_valid, o_resp_tag, o_resp_data
  );
endinterface

// File: rtl/msrh_l2_responder.sv
// L2 responder: FIFO-queued line requests served in order from a line-granular array
// after a programmable latency. States: IDLE (wait for work) | WAIT (latency count) | RESP (hold response).
module msrh_l2_responder #(
  parameter int PADDR_W     = 32,
  parameter int LINE_W      = 256,
  parameter int TAG_W       = 4,
  parameter int MEM_LINES   = 1024,
  parameter int QUEUE_DEPTH = 4,
  parameter int LATENCY     = 4
) (
  input logic      i_clk,
  input logic      i_reset_n,
  msrh_l2_if.slave bus
);
  localparam int LINE_BYTES = LINE_W / 8;
  localparam int OFF_W      = $clog2(LINE_BYTES);
  localparam int IDX_W      = $clog2(MEM_LINES);
  localparam int QA_W       = $clog2(QUEUE_DEPTH);
  localparam int CNT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [QA_W:0]         wr_ptr_q, rd_ptr_q;
  logic                  q_full, q_empty, push, pop, mem_we;

  logic                  q_cmd_q  [QUEUE_DEPTH];
  logic [IDX_W-1:0]      q_idx_q  [QUEUE_DEPTH];
  logic [TAG_W-1:0]      q_tag_q  [QUEUE_DEPTH];
  logic [LINE_W-1:0]     q_data_q [QUEUE_DEPTH];
  logic [LINE_BYTES-1:0] q_be_q   [QUEUE_DEPTH];

  logic                  w_cmd_q;
  logic [IDX_W-1:0]      w_idx_q;
  logic [TAG_W-1:0]      w_tag_q;
  logic [LINE_W-1:0]     w_data_q;
  logic [LINE_BYTES-1:0] w_be_q;

  logic                  resp_valid_q, resp_valid_d;
  logic [TAG_W-1:0]      resp_tag_q, resp_tag_d;
  logic [LINE_W-1:0]     resp_data_q, resp_data_d;

  logic [LINE_W-1:0]     mem_q [MEM_LINES];
  logic [LINE_W-1:0]     mem_rdata, mem_wline;

  // Offset and alias bits above the array are don't-care by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.i_req_addr[PADDR_W-1:OFF_W+IDX_W], bus.i_req_addr[OFF_W-1:0]};

  assign q_empty = (wr_ptr_q == rd_ptr_q);
  assign q_full  = (wr_ptr_q[QA_W] != rd_ptr_q[QA_W]) && (wr_ptr_q[QA_W-1:0] == rd_ptr_q[QA_W-1:0]);
  assign push    = bus.i_req_valid & ~q_full;

  assign bus.o_req_ready  = ~q_full;
  assign bus.o_resp_valid = resp_valid_q;
  assign bus.o_resp_tag   = resp_tag_q;
  assign bus.o_resp_data  = resp_data_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      q_cmd_q[wr_ptr_q[QA_W-1:0]]  <= bus.i_req_cmd;
      q_idx_q[wr_ptr_q[QA_W-1:0]]  <= bus.i_req_addr[OFF_W +: IDX_W];
      q_tag_q[wr_ptr_q[QA_W-1:0]]  <= bus.i_req_tag;
      q_data_q[wr_ptr_q[QA_W-1:0]] <= bus.i_req_data;
      q_be_q[wr_ptr_q[QA_W-1:0]]   <= bus.i_req_byte_en;
    end
    if (pop) begin
      w_cmd_q  <= q_cmd_q[rd_ptr_q[QA_W-1:0]];
      w_idx_q  <= q_idx_q[rd_ptr_q[QA_W-1:0]];
      w_tag_q  <= q_tag_q[rd_ptr_q[QA_W-1:0]];
      w_data_q <= q_data_q[rd_ptr_q[QA_W-1:0]];
      w_be_q   <= q_be_q[rd_ptr_q[QA_W-1:0]];
    end
    if (mem_we) mem_q[w_idx_q] <= mem_wline;
  end

  assign mem_rdata = mem_q[w_idx_q];

  always_comb begin
    mem_wline = mem_rdata;
    for (int b = 0; b < LINE_BYTES; b++) begin
      if (w_be_q[b]) mem_wline[b*8 +: 8] = w_data_q[b*8 +: 8];
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pop          = 1'b0;
    mem_we       = 1'b0;
    resp_valid_d = resp_valid_q;
    resp_tag_d   = resp_tag_q;
    resp_data_d  = resp_data_q;
    case (state_q)
      IDLE: begin
        if (!q_empty) begin
          pop     = 1'b1;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_tag_d   = w_tag_q;
          resp_data_d  = w_cmd_q ? '0 : mem_rdata;
          mem_we       = w_cmd_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (bus.i_resp_ready) begin
          resp_valid_d = 1'b0;
          // Chain straight into the next request to avoid an IDLE bubble.
          if (!q_empty) begin
            pop     = 1'b1;
            cnt_d   = CNT_W'(LATENCY - 1);
            state_d = WAIT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_tag_q   <= '0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_tag_q   <= resp_tag_d;
      resp_data_q  <= resp_data_d;
    end
  end
endmodule

// File: tb/tb_msrh_l2_responder.sv
// Randomized and directed bench for msrh_l2_responder against an in-order line-memory model.
module tb_msrh_l2_responder;
  localparam int AW = 32, LW = 256, LB = 32, TW = 4, ML = 1024, QD = 4, LAT = 4;
  localparam int PER = 10;

  typedef struct {
    logic [TW-1:0] tag;
    logic [LW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #(PER/2) clk = ~clk;

  msrh_l2_if #(.PADDR_W(AW), .LINE_W(LW), .TAG_W(TW)) bus ();

  msrh_l2_responder #(
    .PADDR_W(AW), .LINE_W(LW), .TAG_W(TW), .MEM_LINES(ML), .QUEUE_DEPTH(QD), .LATENCY(LAT)
  ) dut (
    .i_clk(clk),
    .i_reset_n(rst_n),
    .bus(bus)
  );

  exp_t          exp_q[$];
  logic [LW-1:0] mem_m[int];
  time           hs_t[$];
  int            n_vec = 0, n_err = 0;
  logic          rnd_rdy = 1'b0;

  task automatic check_val(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW/32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // Reference: each accepted request is resolved immediately against the model array,
  // which is valid because the responder serves strictly in order.
  function automatic void model_accept(input logic cmd, input logic [AW-1:0] addr,
                                       input logic [TW-1:0] tag, input logic [LW-1:0] data,
                                       input logic [LB-1:0] be);
    int idx;
    logic [LW-1:0] line;
    exp_t e;
    idx  = int'((addr / LB) % ML);
    line = mem_m.exists(idx) ? mem_m[idx] : '0;
    e.tag = tag;
    if (cmd) begin
      for (int b = 0; b < LB; b++) if (be[b]) line[b*8 +: 8] = data[b*8 +: 8];
      mem_m[idx] = line;
      e.data = '0;
    end else begin
      e.data = line;
    end
    exp_q.push_back(e);
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push(input logic cmd, input logic [AW-1:0] addr, input logic [TW-1:0] tag,
                      input logic [LW-1:0] data, input logic [LB-1:0] be);
    logic acc = 1'b0;
    bus.i_req_valid   = 1'b1;
    bus.i_req_cmd     = cmd;
    bus.i_req_addr    = addr;
    bus.i_req_tag     = tag;
    bus.i_req_data    = data;
    bus.i_req_byte_en = be;
    for (int i = 0; i < 400 && !acc; i++) begin
      @(negedge clk);
      acc = bus.o_req_ready;
      @(posedge clk);
      if (acc) model_accept(cmd, addr, tag, data, be);
      #1;
    end
    bus.i_req_valid = 1'b0;
    if (!acc) check_val("push_timeout", 1'b0, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && exp_q.size() > 0; i++) @(negedge clk);
    check_val("drain", LW'(exp_q.size()), '0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.o_resp_valid) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_resp", 1'b1, 1'b0);
      end else begin
        check_val("resp_tag", LW'(bus.o_resp_tag), LW'(exp_q[0].tag));
        check_val("resp_data", bus.o_resp_data, exp_q[0].data);
        if (bus.i_resp_ready) begin
          void'(exp_q.pop_front());
          hs_t.push_back($time);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1;
      bus.i_resp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #(PER * 50000);
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n, sent, stall_ok, seen;
    logic [LW-1:0] x;
    logic [LB-1:0] be;
    int idx;
    logic [AW-1:0] addr;

    bus.i_req_valid   = 1'b0;
    bus.i_req_cmd     = 1'b0;
    bus.i_req_addr    = '0;
    bus.i_req_tag     = '0;
    bus.i_req_data    = '0;
    bus.i_req_byte_en = '0;
    bus.i_resp_ready  = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ready", LW'(bus.o_req_ready), LW'(1));
    check_val("rst_valid", LW'(bus.o_resp_valid), '0);
    check_val("rst_tag", LW'(bus.o_resp_tag), '0);
    check_val("rst_data", bus.o_resp_data, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Write then read with exact first-response latency.
    push(1'b1, 32'h40, 4'd1, {LB{8'hA5}}, '1);
    n = 0;
    while (n < 50 && !bus.o_resp_valid) begin
      @(negedge clk);
      n++;
    end
    check_val("latency", LW'(n), LW'(LAT + 2));
    @(posedge clk);
    #1;
    push(1'b0, 32'h40, 4'd2, '0, '0);
    drain();

    // Partial write.
    push(1'b1, 32'h80, 4'd4, '0, '1);
    x = rand_line();
    x[7:0] = 8'hFF;
    push(1'b1, 32'h80, 4'd5, x, 32'h1);
    push(1'b0, 32'h80, 4'd6, '0, '0);
    drain();

    // Alias.
    x = rand_line();
    push(1'b1, 32'h40, 4'd7, x, '1);
    push(1'b0, 32'h40 + ML*LB, 4'd8, '0, '0);
    drain();

    // Queue full with response stall, then release.
    bus.i_resp_ready = 1'b0;
    sent = 0;
    stall_ok = 0;
    bus.i_req_cmd = 1'b0;
    for (int i = 0; i < 30; i++) begin
      logic rdy;
      bus.i_req_valid = (sent < 6);
      bus.i_req_tag   = TW'(sent);
      bus.i_req_addr  = sent[0] ? 32'h80 : 32'h40;
      @(negedge clk);
      rdy = bus.o_req_ready;
      if (i >= 20 && bus.o_resp_valid) stall_ok++;
      @(posedge clk);
      if (rdy && bus.i_req_valid) begin
        model_accept(1'b0, bus.i_req_addr, bus.i_req_tag, '0, '0);
        sent++;
      end
      #1;
    end
    check_val("full_accepts", LW'(sent), LW'(QD + 1));
    check_val("full_ready", LW'(bus.o_req_ready), '0);
    check_val("stall_valid", LW'(stall_ok), LW'(10));
    hs_t.delete();
    bus.i_resp_ready = 1'b1;
    for (int i = 0; i < 100 && sent < 6; i++) begin
      logic rdy;
      bus.i_req_valid = 1'b1;
      bus.i_req_tag   = TW'(sent);
      bus.i_req_addr  = sent[0] ? 32'h80 : 32'h40;
      @(negedge clk);
      rdy = bus.o_req_ready;
      @(posedge clk);
      if (rdy) begin
        model_accept(1'b0, bus.i_req_addr, bus.i_req_tag, '0, '0);
        sent++;
      end
      #1;
    end
    bus.i_req_valid = 1'b0;
    check_val("full_sent", LW'(sent), LW'(6));
    drain();
    check_val("full_hs_count", LW'(hs_t.size()), LW'(6));
    for (int i = 1; i < hs_t.size(); i++)
      check_val("full_spacing", LW'(hs_t[i] - hs_t[i-1]), LW'((LAT + 1) * PER));

    // Reset while a request sits in WAIT.
    push(1'b0, 32'h40, 4'd3, '0, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_val("midrst_ready", LW'(bus.o_req_ready), LW'(1));
    check_val("midrst_valid", LW'(bus.o_resp_valid), '0);
    check_val("midrst_tag", LW'(bus.o_resp_tag), '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < LAT + 8; i++) begin
      @(negedge clk);
      if (bus.o_resp_valid) seen++;
    end
    check_val("midrst_no_resp", LW'(seen), '0);
    @(posedge clk);
    #1;

    // Randomized traffic over a small aliased line set.
    for (int k = 0; k < 8; k++) push(1'b1, AW'((16 + k) * LB), TW'(k), rand_line(), '1);
    drain();
    rnd_rdy = 1'b1;
    for (int t = 0; t < 80; t++) begin
      idx  = 16 + $urandom_range(0, 7);
      addr = ($urandom() & 32'hFFFF_8000) | AW'(idx * LB) | AW'($urandom_range(0, LB - 1));
      be   = $urandom();
      push($urandom_range(0, 1) == 1, addr, TW'($urandom()), rand_line(), be);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain();
    rnd_rdy = 1'b0;
    #2;
    bus.i_resp_ready = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/msrh_l2_responder.md
Name: msrh_l2_responder

Overview:
- Responder (slave) end of the L2 request/response protocol that the tile drives as master for ICache refills.
- Accepts line requests (read or byte-masked write) and returns in-order responses carrying the request tag after a programmable latency.
- Backed by an internal line-granular memory array.
- Serves as the L2/memory model under the tile in simulation, and as the skeleton for the real L2 front-end.

Parameters:
- PADDR_W, 32, physical address width.
- LINE_W, 256, line data width in bits; LINE_BYTES = LINE_W/8.
- TAG_W, 4, request tag width.
- MEM_LINES, 1024, number of lines in the array (power of 2).
- QUEUE_DEPTH, 4, request queue entries (power of 2, ≥2).
- LATENCY, 4, wait cycles between queue pop and response valid (≥1).

Ports:
- i_clk, input, 1, clock.
- i_reset_n, input, 1, asynchronous active-low reset.
- i_req_valid, input, 1, request valid.
- o_req_ready, output, 1, request accept; equals queue not full.
- i_req_cmd, input, 1, 0 = read, 1 = write.
- i_req_addr, input, PADDR_W, byte address; low log2(LINE_BYTES) bits ignored.
- i_req_tag, input, TAG_W, requester tag.
- i_req_data, input, LINE_W, write data.
- i_req_byte_en, input, LINE_BYTES, write byte enables.
- o_resp_valid, output, 1, response valid.
- i_resp_ready, input, 1, response accept.
- o_resp_tag, output, TAG_W, tag of the answered request.
- o_resp_data, output, LINE_W, read data; zero for write acks.

Behaviour:
- Reset (async, i_reset_n low):
  - Queue empty (o_req_ready=1), FSM in IDLE, wait counter 0.
  - o_resp_valid=0, o_resp_tag=0, o_resp_data=0.
  - Memory array is not reset.
  - Reset mid-operation discards all queued and in-flight requests; no response is issued for them.
- Request handshake:
  - A request is accepted on a rising edge with i_req_valid & o_req_ready; it is pushed to the FIFO queue.
  - o_req_ready is combinational from registered queue state only. It does not depend on i_req_valid or the pop in the same cycle.
- Line index: i_req_addr[log2(LINE_BYTES) +: log2(MEM_LINES)]. Upper address bits are ignored, so addresses alias modulo the array size.
- FSM states:
  - IDLE: if queue non-empty, pop head into a working register, load counter = LATENCY-1, go to WAIT.
  - WAIT: decrement the counter. When the counter is 0, go to RESP and register the response:
    - read: o_resp_data = mem[index].
    - write: apply byte enables to mem[index]; o_resp_data = 0.
    - o_resp_tag = working tag; o_resp_valid = 1.
  - RESP: hold o_resp_valid, tag and data stable until i_resp_ready. On the handshake edge:
    - if queue non-empty, pop the next request, load the counter and go to WAIT (no IDLE bubble);
    - otherwise clear o_resp_valid and go to IDLE.
- Latency and throughput:
  - Request accepted into an empty queue with the FSM in IDLE at edge T: o_resp_valid is first high in the cycle after edge T+1+LATENCY.
  - Steady-state throughput: one response per LATENCY+1 cycles with i_resp_ready held high.
- Ordering: strictly in-order. A read after a write to the same line (either order of enqueue) observes the write.
- Queue:
  - Push and pop in the same edge are legal, and occupancy is unchanged.
  - When full, push is blocked by o_req_ready=0. A pop in that same cycle does not make ready rise until the next cycle.
  - Pointers wrap modulo QUEUE_DEPTH; an extra bit distinguishes full from empty.
- Backpressure: i_resp_ready low for any number of cycles stalls the FSM in RESP. The queue keeps accepting until full.

Test Plan:
- Reset: hold i_reset_n=0 → o_req_ready=1, o_resp_valid=0, o_resp_tag=0; assert reset while in WAIT → no response after release.
- Write then read: write addr 0x40, tag 1, data 0xA5 repeated, byte_en all ones; then read 0x40, tag 2 → ack tag 1 with data 0; read tag 2 returns 0xA5 pattern; first valid exactly LATENCY+2 cycles after the accepting edge.
- Partial write: mem line 0x80 = all 0x00; write byte_en=0x1, data byte0=0xFF; read 0x80 → byte0=0xFF, other bytes 0x00.
- Queue full: i_resp_ready=0, issue 6 reads with tags 0..5 → o_req_ready falls after 4 accepts, plus the one held in the FSM; raise i_resp_ready → responses arrive with tags 0..5 in order, spaced LATENCY+1 cycles apart.
- Response stall: hold i_resp_ready=0 for 10 cycles during RESP → o_resp_valid, tag and data stay constant across all 10 cycles.
- Alias: write addr 0x40 data X; read addr 0x40 + MEM_LINES*LINE_BYTES → returns X.
